// File: rtl/control_unit_fft_iter_cfg_pkg.sv
// Shared definitions for the iterative radix-2 FFT control unit:
// state encoding, read-latency limit and the butterflies-per-layer helper.
package control_unit_fft_iter_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DELAY = 3'd2,
        ST_STROB = 3'd3,
        ST_WRITE = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    localparam int unsigned RD_LAT_MAX = 7;
    localparam int unsigned DLY_W      = $clog2(RD_LAT_MAX + 1);

    // Butterflies per layer for a 2^l point radix-2 transform (0 when l is 0).
    function automatic int unsigned butt_per_layer(input int unsigned l);
        if (l == 32'd0) begin
            return 32'd0;
        end
        return 32'd1 << (l - 32'd1);
    endfunction

endpackage

// File: rtl/fft_iter_idx_cnt.sv
// Butterfly / layer index counter: butterfly index wraps at B-1 and then
// advances the layer index.
module fft_iter_idx_cnt
    import control_unit_fft_iter_cfg_pkg::*;
#(
    parameter int unsigned LayWL  = 3,
    parameter int unsigned ButtWL = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clear,
    input  logic              step,
    input  logic [ButtWL:0]   B,
    input  logic [LayWL-1:0]  L,
    output logic [ButtWL-1:0] BUT_CNT,
    output logic [LayWL-1:0]  LAY_CNT,
    output logic              last_butt,
    output logic              last_lay
);

    localparam int unsigned BW = ButtWL + 1;

    logic [ButtWL-1:0] but_q;
    logic [LayWL-1:0]  lay_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            but_q <= '0;
            lay_q <= '0;
        end else if (clear) begin
            but_q <= '0;
            lay_q <= '0;
        end else if (step) begin
            if (last_butt) begin
                but_q <= '0;
                lay_q <= lay_q + LayWL'(1);
            end else begin
                but_q <= but_q + ButtWL'(1);
            end
        end
    end

    // Compare in B's width so B=2^ButtWL never truncates.
    assign last_butt = ({1'b0, but_q} == (B - BW'(1)));
    assign last_lay  = (lay_q == (L - LayWL'(1)));

    assign BUT_CNT = but_q;
    assign LAY_CNT = lay_q;

endmodule

// File: rtl/control_unit_fft_iter_cfg.sv
// Control unit sequencing an in-place iterative radix-2 FFT of run-time
// selectable size: READ, optional read-latency DELAY, STROB, WRITE per butterfly.
module control_unit_fft_iter_cfg
    import control_unit_fft_iter_cfg_pkg::*;
#(
    parameter int unsigned LOG2N_MAX = 5,
    parameter int unsigned LayWL     = 3,
    parameter int unsigned ButtWL    = 4,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              START,
    input  logic [LayWL-1:0]  CFG_LOG2N,
    output logic              BUT_STROB,
    output logic              LAY_EN,
    output logic              ADDR_EN,
    output logic              RAM_EN,
    output logic              Wr,
    output logic              FIRST,
    output logic              LAST,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [ButtWL-1:0] BUT_CNT,
    output logic [LayWL-1:0]  LAY_CNT
);

    localparam int unsigned BW = ButtWL + 1;

    state_t             state_q, state_n;
    logic [LayWL-1:0]   l_q, l_n;
    logic [BW-1:0]      b_q, b_n;
    logic [DLY_W-1:0]   dly_q, dly_n;
    logic               err_q, err_n;
    logic               cnt_clear, cnt_step;
    logic               last_butt, last_lay;
    logic               cfg_valid;

    assign cfg_valid = (CFG_LOG2N != '0) && (32'(CFG_LOG2N) <= LOG2N_MAX);

    // State and configuration registers; EN low freezes everything but reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            l_q     <= '0;
            b_q     <= '0;
            dly_q   <= '0;
            err_q   <= 1'b0;
        end else if (EN) begin
            state_q <= state_n;
            l_q     <= l_n;
            b_q     <= b_n;
            dly_q   <= dly_n;
            err_q   <= err_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n   = state_q;
        l_n       = l_q;
        b_n       = b_q;
        dly_n     = dly_q;
        err_n     = 1'b0;
        cnt_clear = 1'b0;
        cnt_step  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (cfg_valid) begin
                        state_n   = ST_READ;
                        l_n       = CFG_LOG2N;
                        b_n       = BW'(butt_per_layer(32'(CFG_LOG2N)));
                        cnt_clear = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ST_READ: begin
                dly_n   = '0;
                state_n = (RD_LAT == 32'd0) ? ST_STROB : ST_DELAY;
            end
            ST_DELAY: begin
                if (32'(dly_q) == (RD_LAT - 32'd1)) begin
                    state_n = ST_STROB;
                end else begin
                    dly_n = dly_q + DLY_W'(1);
                end
            end
            ST_STROB: begin
                state_n = ST_WRITE;
            end
            ST_WRITE: begin
                cnt_step = 1'b1;
                state_n  = (last_butt && last_lay) ? ST_FIN : ST_READ;
            end
            ST_FIN: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    fft_iter_idx_cnt #(
        .LayWL (LayWL),
        .ButtWL(ButtWL)
    ) u_idx_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (cnt_clear & EN),
        .step     (cnt_step & EN),
        .B        (b_q),
        .L        (l_q),
        .BUT_CNT  (BUT_CNT),
        .LAY_CNT  (LAY_CNT),
        .last_butt(last_butt),
        .last_lay (last_lay)
    );

    // Strobes are decoded from registered state and masked while EN is low.
    assign BUSY      = (state_q != ST_IDLE);
    assign RAM_EN    = EN & ((state_q == ST_READ) | (state_q == ST_WRITE));
    assign BUT_STROB = EN & (state_q == ST_STROB);
    assign Wr        = EN & (state_q == ST_WRITE);
    assign ADDR_EN   = EN & (state_q == ST_WRITE);
    assign LAY_EN    = EN & (state_q == ST_WRITE) & last_butt & ~last_lay;
    assign DONE      = EN & (state_q == ST_FIN);
    assign ERR       = EN & err_q;
    assign FIRST     = BUSY & (LAY_CNT == '0);
    assign LAST      = BUSY & last_lay;

endmodule

// File: tb/tb_control_unit_fft_iter_cfg.sv
// Bench for control_unit_fft_iter_cfg: RD_LAT=1 and RD_LAT=0 builds share
// stimulus and are compared every cycle against a position-based model.
module tb_control_unit_fft_iter_cfg;

    localparam int unsigned LAYW = 3;
    localparam int unsigned BUTW = 4;
    localparam int          LMAX = 5;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic            EN = 1'b0;
    logic            START = 1'b0;
    logic [LAYW-1:0] CFG_LOG2N = '0;

    logic [1:0] bs, le, ae, re, wr, fi, la, bu, dn, er;
    logic [BUTW-1:0] bc [2];
    logic [LAYW-1:0] lc [2];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Model: per instance, active flag, L, 1-based enabled position in transform.
    int m_act [2];
    int m_L   [2];
    int m_p   [2];
    int m_err [2];
    int m_ilay[2];
    int m_ibut[2];

    // Scenario statistics.
    int rel;
    int c_wr[2], c_le[2], c_bs[2], c_busy[2], c_last[2], c_first[2], c_errp[2];
    int done_at[2], last_first[2], c_off[2];

    always #5 CLK = ~CLK;

    control_unit_fft_iter_cfg #(.LOG2N_MAX(5), .LayWL(3), .ButtWL(4), .RD_LAT(1)) u_dut (
        .CLK(CLK), .RST(RST), .EN(EN), .START(START), .CFG_LOG2N(CFG_LOG2N),
        .BUT_STROB(bs[0]), .LAY_EN(le[0]), .ADDR_EN(ae[0]), .RAM_EN(re[0]), .Wr(wr[0]),
        .FIRST(fi[0]), .LAST(la[0]), .BUSY(bu[0]), .DONE(dn[0]), .ERR(er[0]),
        .BUT_CNT(bc[0]), .LAY_CNT(lc[0])
    );

    control_unit_fft_iter_cfg #(.LOG2N_MAX(5), .LayWL(3), .ButtWL(4), .RD_LAT(0)) u_dut_rl0 (
        .CLK(CLK), .RST(RST), .EN(EN), .START(START), .CFG_LOG2N(CFG_LOG2N),
        .BUT_STROB(bs[1]), .LAY_EN(le[1]), .ADDR_EN(ae[1]), .RAM_EN(re[1]), .Wr(wr[1]),
        .FIRST(fi[1]), .LAST(la[1]), .BUSY(bu[1]), .DONE(dn[1]), .ERR(er[1]),
        .BUT_CNT(bc[1]), .LAY_CNT(lc[1])
    );

    function automatic int rl(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input int i, input logic st, input logic [2:0] cfg,
                              input logic en, input logic rst);
        int b, n;
        if (!rst) begin
            m_act[i] = 0; m_L[i] = 0; m_p[i] = 0; m_err[i] = 0; m_ilay[i] = 0; m_ibut[i] = 0;
        end else if (en) begin
            m_err[i] = 0;
            if (m_act[i] == 0) begin
                if (st) begin
                    if (int'(cfg) >= 1 && int'(cfg) <= LMAX) begin
                        m_act[i] = 1; m_L[i] = int'(cfg); m_p[i] = 1;
                    end else begin
                        m_err[i] = 1;
                    end
                end
            end else begin
                b = 1 << (m_L[i] - 1);
                n = m_L[i] * b * (3 + rl(i));
                if (m_p[i] == n + 1) begin
                    m_act[i] = 0; m_ilay[i] = m_L[i]; m_ibut[i] = 0;
                end else begin
                    m_p[i]++;
                end
            end
        end
    endtask

    function automatic logic [31:0] exp_vec(input int i, input logic en);
        int b, n, r, k, ph, lay, but;
        logic busy, done, ram, strob, wrr, layen, first, last, err;
        r = rl(i);
        busy = 0; done = 0; ram = 0; strob = 0; wrr = 0; layen = 0; first = 0; last = 0;
        lay = m_ilay[i]; but = m_ibut[i];
        if (m_act[i] != 0) begin
            busy = 1;
            b = 1 << (m_L[i] - 1);
            n = m_L[i] * b * (3 + r);
            if (m_p[i] <= n) begin
                k = (m_p[i] - 1) / (3 + r);
                ph = (m_p[i] - 1) % (3 + r);
                lay = k / b;
                but = k % b;
                ram = (ph == 0) || (ph == r + 2);
                strob = (ph == r + 1);
                wrr = (ph == r + 2);
                layen = wrr && (but == b - 1) && (lay < m_L[i] - 1);
            end else begin
                done = 1; lay = m_L[i]; but = 0;
            end
            first = (lay == 0);
            last = (lay == m_L[i] - 1);
        end
        err = (m_err[i] != 0);
        ram &= en; strob &= en; wrr &= en; layen &= en; done &= en; err &= en;
        return {15'd0, busy, done, err, ram, strob, wrr, wrr, layen, first, last,
                3'(lay), 4'(but)};
    endfunction

    function automatic logic [31:0] got_vec(input int i);
        return {15'd0, bu[i], dn[i], er[i], re[i], bs[i], wr[i], ae[i], le[i],
                fi[i], la[i], lc[i], bc[i]};
    endfunction

    task automatic clear_stats();
        rel = 0;
        for (int i = 0; i < 2; i++) begin
            c_wr[i] = 0; c_le[i] = 0; c_bs[i] = 0; c_busy[i] = 0; c_last[i] = 0;
            c_first[i] = 0; c_errp[i] = 0; done_at[i] = -1; last_first[i] = -1; c_off[i] = 0;
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare #1 later.
    task automatic tick(input logic st, input logic [2:0] cfg, input logic en, input logic rst);
        START = st; CFG_LOG2N = cfg; EN = en; RST = rst;
        @(posedge CLK);
        for (int i = 0; i < 2; i++) model_step(i, st, cfg, en, rst);
        #1;
        cyc++;
        rel++;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("cyc%0d_dut%0d", cyc, i), got_vec(i), exp_vec(i, en));
            if (wr[i]) c_wr[i]++;
            if (le[i]) c_le[i]++;
            if (bs[i]) c_bs[i]++;
            if (bu[i]) c_busy[i]++;
            if (fi[i]) c_first[i]++;
            if (er[i]) c_errp[i]++;
            if (la[i]) begin
                c_last[i]++;
                if (last_first[i] < 0) last_first[i] = rel;
            end
            if (dn[i] && done_at[i] < 0) done_at[i] = rel;
            if (!en && (re[i] | bs[i] | wr[i] | ae[i] | le[i] | dn[i] | er[i])) c_off[i]++;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 3'd0, 1'b1, 1'b1);
    endtask

    task automatic run_until_done(input int budget);
        for (int k = 0; k < budget && (done_at[0] < 0 || done_at[1] < 0); k++)
            tick(1'b0, 3'd0, 1'b1, 1'b1);
        idle(2);
    endtask

    initial begin
        clear_stats();
        // Reset with EN low still resets.
        tick(1'b0, 3'd0, 1'b0, 1'b0);
        tick(1'b0, 3'd0, 1'b0, 1'b0);
        check("reset_out_rl1", got_vec(0), 32'd0);
        check("reset_out_rl0", got_vec(1), 32'd0);
        idle(2);

        // L=3 transform.
        clear_stats();
        tick(1'b1, 3'd3, 1'b1, 1'b1);
        run_until_done(2000);
        check("l3_done", done_at[0], 49);
        check("l3_wr", c_wr[0], 12);
        check("l3_layen", c_le[0], 2);
        check("l3_busy", c_busy[0], 49);
        check("l3_done_rl0", done_at[1], 37);

        // L=5 transform.
        clear_stats();
        tick(1'b1, 3'd5, 1'b1, 1'b1);
        run_until_done(2000);
        check("l5_done", done_at[0], 321);
        check("l5_strob", c_bs[0], 80);
        check("l5_layen", c_le[0], 4);
        check("l5_last_cnt", c_last[0], 64);
        check("l5_last_start", last_first[0], 257);
        check("l5_done_rl0", done_at[1], 241);

        // Illegal sizes.
        clear_stats();
        tick(1'b1, 3'd0, 1'b1, 1'b1);
        idle(3);
        check("cfg0_err", c_errp[0], 1);
        check("cfg0_busy", c_busy[0], 0);
        clear_stats();
        tick(1'b1, 3'd6, 1'b1, 1'b1);
        idle(3);
        check("cfg6_err", c_errp[0], 1);
        check("cfg6_busy", c_busy[1], 0);

        // START mid-run is ignored.
        clear_stats();
        tick(1'b1, 3'd3, 1'b1, 1'b1);
        idle(19);
        tick(1'b1, 3'd5, 1'b1, 1'b1);
        run_until_done(2000);
        check("restart_done", done_at[0], 49);
        check("restart_done_rl0", done_at[1], 37);
        check("restart_err", c_errp[0], 0);

        // EN low for 7 cycles inside DELAY.
        clear_stats();
        tick(1'b1, 3'd3, 1'b1, 1'b1);
        tick(1'b0, 3'd0, 1'b1, 1'b1);
        for (int k = 0; k < 7; k++) tick(1'b0, 3'd0, 1'b0, 1'b1);
        run_until_done(2000);
        check("gap_done", done_at[0], 56);
        check("gap_done_rl0", done_at[1], 44);
        check("gap_strobes", c_off[0], 0);

        // Reset in layer 2, then L=1.
        clear_stats();
        tick(1'b1, 3'd3, 1'b1, 1'b1);
        idle(39);
        tick(1'b0, 3'd0, 1'b1, 1'b0);
        check("midrst_out_rl1", got_vec(0), 32'd0);
        check("midrst_out_rl0", got_vec(1), 32'd0);
        tick(1'b0, 3'd0, 1'b1, 1'b1);
        clear_stats();
        tick(1'b1, 3'd1, 1'b1, 1'b1);
        run_until_done(200);
        check("l1_done", done_at[0], 5);
        check("l1_first", c_first[0], 4);
        check("l1_last", c_last[0], 4);
        check("l1_layen", c_le[0], 0);
        check("l1_done_rl0", done_at[1], 4);

        // L=4, 3 cycles per butterfly on the RD_LAT=0 build.
        clear_stats();
        tick(1'b1, 3'd4, 1'b1, 1'b1);
        run_until_done(2000);
        check("l4_done_rl0", done_at[1], 97);
        check("l4_done", done_at[0], 129);

        // Random traffic.
        for (int k = 0; k < 4000; k++) begin
            tick(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 299) != 0) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
